// File: rtl/dip_edge_detect.sv
// dip_edge_detect: streaming 3x3 Sobel/Prewitt edge detector.
// Grey pixels in, one RGB565 word per interior window out.
module dip_edge_detect #(
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 1024,
  parameter int IMG_H   = 768,
  parameter int THR_DEF = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dip_en,
  input  logic [DATA_W-1:0] dip_data,
  input  logic [DATA_W+2:0] thr,
  input  logic [1:0]        mode,
  input  logic              invert,
  output logic              sdram_wr_en,
  output logic [15:0]       sdram_wr_data,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DATA_W + 4;
  localparam int MW = DATA_W + 3;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb2_q [IMG_W];

  logic [DATA_W-1:0] w11_q, w12_q;
  logic [DATA_W-1:0] w21_q, w22_q;
  logic [DATA_W-1:0] w31_q, w32_q;
  logic [DATA_W-1:0] p13, p23;

  logic [MW-1:0] cfg_thr_q;
  logic [1:0]    cfg_mode_q;
  logic          cfg_inv_q;

  logic win_vld, win_last, first_px;

  logic signed [GW-1:0] e11, e12, e13;
  logic signed [GW-1:0] e21, e23;
  logic signed [GW-1:0] e31, e32, e33;
  logic signed [GW-1:0] sx, sy, px, py;
  logic signed [GW-1:0] gx_d, gy_d;

  logic                 s1_vld_q, s1_last_q;
  logic signed [GW-1:0] gx_q, gy_q;
  logic [MW-1:0]        s1_thr_q;
  logic [1:0]           s1_mode_q;
  logic                 s1_inv_q;
  logic [5:0]           s1_pix_q;

  logic [MW-1:0] ax, ay, mag_d;
  logic [5:0]    sat_d, g_d;
  logic          edge_d;

  logic       s2_vld_q, s2_last_q;
  logic       s2_bin_q, s2_edge_q;
  logic [5:0] s2_g_q;

  logic        wr_en_q, done_q;
  logic [15:0] data_q, data_d;

  assign p13 = lb2_q[col_q];
  assign p23 = lb1_q[col_q];

  assign first_px = dip_en && (col_q == '0) && (row_q == '0);
  assign win_vld  = dip_en && (col_q >= CW'(2)) && (row_q >= RW'(2));
  assign win_last = win_vld && (col_q == COL_MAX) && (row_q == ROW_MAX);

  // raster position of the next accepted pixel
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (dip_en) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // position counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // line buffers and window shift; contents need no reset
  always_ff @(posedge clk) begin
    if (dip_en) begin
      lb1_q[col_q] <= dip_data;
      lb2_q[col_q] <= lb1_q[col_q];
      w11_q <= w12_q;
      w12_q <= p13;
      w21_q <= w22_q;
      w22_q <= p23;
      w31_q <= w32_q;
      w32_q <= dip_data;
    end
  end

  // per-frame configuration latched on pixel (0,0)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_thr_q  <= MW'(THR_DEF);
      cfg_mode_q <= 2'b00;
      cfg_inv_q  <= 1'b0;
    end else if (first_px) begin
      cfg_thr_q  <= thr;
      cfg_mode_q <= mode;
      cfg_inv_q  <= invert;
    end
  end

  assign e11 = $signed({4'b0, w11_q});
  assign e12 = $signed({4'b0, w12_q});
  assign e13 = $signed({4'b0, p13});
  assign e21 = $signed({4'b0, w21_q});
  assign e23 = $signed({4'b0, p23});
  assign e31 = $signed({4'b0, w31_q});
  assign e32 = $signed({4'b0, w32_q});
  assign e33 = $signed({4'b0, dip_data});

  // gradient over the live window, operator picked by frame mode
  always_comb begin
    sx = (e13 + (e23 <<< 1) + e33) - (e11 + (e21 <<< 1) + e31);
    sy = (e31 + (e32 <<< 1) + e33) - (e11 + (e12 <<< 1) + e13);
    px = (e13 + e23 + e33) - (e11 + e21 + e31);
    py = (e31 + e32 + e33) - (e11 + e12 + e13);
    gx_d = sx;
    gy_d = sy;
    if (cfg_mode_q == 2'b01) begin
      gx_d = px;
      gy_d = py;
    end
  end

  // S1: gradients plus the config that travels with them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      gx_q      <= '0;
      gy_q      <= '0;
      s1_thr_q  <= '0;
      s1_mode_q <= 2'b00;
      s1_inv_q  <= 1'b0;
      s1_pix_q  <= '0;
    end else begin
      s1_vld_q  <= win_vld;
      s1_last_q <= win_last;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      s1_thr_q  <= cfg_thr_q;
      s1_mode_q <= cfg_mode_q;
      s1_inv_q  <= cfg_inv_q;
      s1_pix_q  <= w22_q[DATA_W-1 -: 6];
    end
  end

  // magnitude, saturation and threshold compare
  always_comb begin
    ax     = gx_q[GW-1] ? MW'(-gx_q) : MW'(gx_q);
    ay     = gy_q[GW-1] ? MW'(-gy_q) : MW'(gy_q);
    mag_d  = ax + ay;
    sat_d  = (|mag_d[MW-1:DATA_W]) ? '1 : mag_d[DATA_W-1 -: 6];
    g_d    = (s1_mode_q == 2'b11) ? s1_pix_q : sat_d;
    edge_d = (mag_d > s1_thr_q) ^ s1_inv_q;
  end

  // S2: edge decision and grey level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_bin_q  <= 1'b0;
      s2_edge_q <= 1'b0;
      s2_g_q    <= '0;
    end else begin
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_bin_q  <= ~s1_mode_q[1];
      s2_edge_q <= edge_d;
      s2_g_q    <= g_d;
    end
  end

  // RGB565 packing; idle cycles drive zero
  always_comb begin
    data_d = 16'h0000;
    if (s2_vld_q) begin
      if (s2_bin_q) begin
        data_d = {16{s2_edge_q}};
      end else begin
        data_d = {s2_g_q[5:1], s2_g_q, s2_g_q[5:1]};
      end
    end
  end

  // S3: output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      data_q  <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      wr_en_q <= s2_vld_q;
      data_q  <= data_d;
      done_q  <= s2_vld_q & s2_last_q;
    end
  end

  assign sdram_wr_en   = wr_en_q;
  assign sdram_wr_data = data_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_dip_edge_detect.sv
// tb_dip_edge_detect: scoreboard bench for dip_edge_detect.
// Expected words are queued at drive time and popped on output.
module tb_dip_edge_detect;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dip_en = 1'b0;
  logic [7:0]  dip_data = '0;
  logic [10:0] thr = 11'd12;
  logic [1:0]  mode = 2'b00;
  logic        invert = 1'b0;
  logic        sdram_wr_en;
  logic [15:0] sdram_wr_data;
  logic        frame_done;

  dip_edge_detect #(
    .DATA_W(8), .IMG_W(W), .IMG_H(H), .THR_DEF(12)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dip_en(dip_en), .dip_data(dip_data),
    .thr(thr), .mode(mode), .invert(invert),
    .sdram_wr_en(sdram_wr_en),
    .sdram_wr_data(sdram_wr_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        done;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int nw = 0, nd = 0, nff = 0, n861 = 0;
  int img [H][W];
  logic [10:0] m_thr;
  logic [1:0]  m_mode;
  logic        m_inv;
  int rst_e;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  function automatic logic [15:0] model(int r, int c);
    int p [3][3];
    int k, gx, gy, mag;
    logic [7:0] g;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[r-2+i][c-2+j];
    k = (m_mode == 2'b01) ? 1 : 2;
    gx = (p[0][2] + k*p[1][2] + p[2][2])
       - (p[0][0] + k*p[1][0] + p[2][0]);
    gy = (p[2][0] + k*p[2][1] + p[2][2])
       - (p[0][0] + k*p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m_mode[1] == 1'b0)
      return (((mag > int'(m_thr)) ? 1'b1 : 1'b0) ^ m_inv)
             ? 16'hFFFF : 16'h0000;
    if (m_mode == 2'b10) g = 8'((mag > 255) ? 255 : mag);
    else g = 8'(p[1][1]);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

  task automatic set_img(input int kind, input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = v;
          1: img[r][c] = (c < 4) ? 0 : v;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic drive_pix(input int r, input int c, input int gap);
    repeat (gap) begin
      @(negedge clk);
      dip_en = 1'b0;
    end
    @(negedge clk);
    dip_en = 1'b1;
    dip_data = 8'(img[r][c]);
    if (r == 0 && c == 0) begin
      m_thr = thr;
      m_mode = mode;
      m_inv = invert;
    end
    if (r >= 2 && c >= 2)
      q.push_back('{model(r, c), (r == H-1 && c == W-1), cyc + 1});
  endtask

  task automatic frame(input int gapmax, input int mid_thr);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (mid_thr >= 0 && r == 2 && c == 4) thr = 11'(mid_thr);
        drive_pix(r, c, int'($urandom_range(gapmax)));
      end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dip_en = 1'b0;
    end
  endtask

  task automatic settle(input int nf, input int eff, input int e861);
    idle(6);
    chk("words", nw, 24 * nf);
    chk("frame_done_cnt", nd, nf);
    chk("queue_left", q.size(), 0);
    if (eff >= 0) chk("ffff_cnt", nff, eff);
    if (e861 >= 0) chk("0861_cnt", n861, e861);
    q.delete();
    nw = 0; nd = 0; nff = 0; n861 = 0;
  endtask

  always @(negedge clk) begin
    if (sdram_wr_en === 1'b1) begin
      nw++;
      if (frame_done === 1'b1) nd++;
      if (sdram_wr_data == 16'hFFFF) nff++;
      if (sdram_wr_data == 16'h0861) n861++;
      if (q.size() == 0) begin
        chk("spurious_word", 1, 0);
      end else begin
        e = q.pop_front();
        chk("data", sdram_wr_data, e.d);
        chk("frame_done", frame_done, e.done);
        chk("latency", cyc, e.acc + 2);
      end
    end else if (cyc > 0 &&
                 (sdram_wr_en !== 1'b0 || frame_done !== 1'b0)) begin
      chk("idle_out", {sdram_wr_en, frame_done}, 2'b00);
    end
  end

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("rst_wr_en", sdram_wr_en, 0);
      chk("rst_data", sdram_wr_data, 0);
      chk("rst_done", frame_done, 0);
    end
    rst_n = 1'b1;

    set_img(0, 100);
    frame(0, -1); settle(1, 0, 0);

    set_img(1, 200);
    frame(0, -1); settle(1, 8, 0);
    invert = 1'b1;
    frame(0, -1); settle(1, 16, 0);
    invert = 1'b0;

    set_img(1, 3);
    frame(0, -1); settle(1, 0, 0);
    thr = 11'd11;
    frame(0, -1); settle(1, 8, 0);
    mode = 2'b01; thr = 11'd8;
    frame(0, -1); settle(1, 8, 0);
    mode = 2'b10;
    frame(0, -1); settle(1, 0, 8);
    set_img(1, 200);
    frame(0, -1); settle(1, 8, 0);

    mode = 2'b11;
    set_img(2, 0);
    frame(0, -1); settle(1, -1, -1);
    mode = 2'b01; thr = 11'd300;
    frame(1, -1); settle(1, -1, -1);

    mode = 2'b00; thr = 11'd11;
    set_img(1, 3);
    frame(3, 12);
    frame(0, -1);
    settle(2, 8, 0);

    set_img(2, 0);
    mode = 2'b00; thr = 11'd100;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        drive_pix(r, c, 0);
    @(negedge clk);
    dip_en = 1'b0;
    rst_n = 1'b0;
    rst_e = cyc + 1;
    while (q.size() > 0 && q[$].acc + 2 >= rst_e)
      void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_wr_en", sdram_wr_en, 0);
    chk("midrst_data", sdram_wr_data, 0);
    chk("midrst_done", frame_done, 0);
    chk("midrst_queue", q.size(), 0);
    nw = 0; nd = 0; nff = 0; n861 = 0;
    set_img(2, 0);
    thr = 11'd60;
    frame(0, -1); settle(1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
